// File: rtl/demux4_reg_pkg.sv
// rtl/demux4_reg_pkg.sv - shared select codes and width for the 4-slot write demux
package demux4_reg_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Same encodings as the 4:1 read mux select, so one controller field drives both.
  localparam logic [1:0] SEL_S0 = 2'd0;
  localparam logic [1:0] SEL_S1 = 2'd1;
  localparam logic [1:0] SEL_S2 = 2'd2;
  localparam logic [1:0] SEL_S3 = 2'd3;

  function automatic logic [3:0] sel_decode(input logic [1:0] sel);
    logic [3:0] oh;
    oh = 4'b0000;
    case (sel)
      SEL_S0:  oh = 4'b0001;
      SEL_S1:  oh = 4'b0010;
      SEL_S2:  oh = 4'b0100;
      SEL_S3:  oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one holding slot: data register plus full flag
module demux_slot
  import demux4_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] E,
  input  logic             ack,
  output logic [WIDTH-1:0] S,
  output logic             full
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             full_d, full_q;

  // Load wins over ack so a same-edge drain and refill keeps the slot full.
  // Ack leaves the data in place; only the flag drops.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = E;
      full_d = 1'b1;
    end else if (ack) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign S    = data_q;
  assign full = full_q;

endmodule

// File: rtl/demux4_reg.sv
// rtl/demux4_reg.sv - steers one write word into one of four independently drained slots
module demux4_reg
  import demux4_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] E,
  input  logic             wr,
  input  logic [3:0]       ack,
  output logic             ready,
  output logic [WIDTH-1:0] S0,
  output logic [WIDTH-1:0] S1,
  output logic [WIDTH-1:0] S2,
  output logic [WIDTH-1:0] S3,
  output logic [3:0]       full,
  output logic             ovf
);

  logic [3:0]       sel_oh;
  logic [3:0]       load;
  logic [WIDTH-1:0] slot_s [4];
  logic             ovf_d, ovf_q;

  assign sel_oh = sel_decode(sel);

  // An ack on the selected slot frees it this edge, so the write can land.
  assign ready = |(sel_oh & (~full | ack));
  assign load  = sel_oh & {4{wr & ready}};

  always_comb begin
    ovf_d = ovf_q;
    if (wr && !ready) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;

  for (genvar n = 0; n < 4; n++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (load[n]),
      .E     (E),
      .ack   (ack[n]),
      .S     (slot_s[n]),
      .full  (full[n])
    );
  end

  assign S0 = slot_s[0];
  assign S1 = slot_s[1];
  assign S2 = slot_s[2];
  assign S3 = slot_s[3];

endmodule

// File: tb/tb_demux4_reg.sv
// tb/tb_demux4_reg.sv - self-checking bench for demux4_reg against a slot-level model
module tb_demux4_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic [31:0] E;
  logic        wr;
  logic [3:0]  ack;
  logic        ready;
  logic [31:0] S0, S1, S2, S3;
  logic [3:0]  full;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_s [4];
  logic [3:0]  m_full;
  logic        m_ovf;

  demux4_reg #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .E     (E),
    .wr    (wr),
    .ack   (ack),
    .ready (ready),
    .S0    (S0),
    .S1    (S1),
    .S2    (S2),
    .S3    (S3),
    .full  (full),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_S0"}, S0, m_s[0]);
    check({tag, "_S1"}, S1, m_s[1]);
    check({tag, "_S2"}, S2, m_s[2]);
    check({tag, "_S3"}, S3, m_s[3]);
    check({tag, "_full"}, {28'd0, full}, {28'd0, m_full});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  task automatic model_clear();
    for (int n = 0; n < 4; n++) m_s[n] = 32'd0;
    m_full = 4'b0000;
    m_ovf  = 1'b0;
  endtask

  // One clock: drive at negedge, check combinational ready, then registered state after the edge.
  task automatic step(input string tag, input logic w, input logic [1:0] s,
                      input logic [31:0] e, input logic [3:0] a);
    logic slot_free;
    @(negedge clk);
    wr = w; sel = s; E = e; ack = a;
    #1;
    slot_free = !m_full[s] || a[s];
    check({tag, "_ready"}, {31'd0, ready}, {31'd0, slot_free});
    @(posedge clk);
    if (w && slot_free) m_s[s] = e;
    for (int n = 0; n < 4; n++) if (a[n]) m_full[n] = 1'b0;
    if (w && slot_free) m_full[s] = 1'b1;
    else if (w) m_ovf = 1'b1;
    #1;
    check_state(tag);
  endtask

  // Reset raised between edges, with whatever inputs are currently driven left in place.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_clear();
    check_state({tag, "_async"});
    @(posedge clk);
    #1;
    check_state({tag, "_held"});
    @(negedge clk);
    reset = 1'b0;
    wr = 1'b0; ack = 4'b0000;
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; sel = 2'd0; E = 32'd0; ack = 4'b0000;
    model_clear();
    #1;
    check_state("por");
    @(posedge clk);
    #1;
    check_state("por_edge");
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-operation with a write still driven
    step("t1_fill", 1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    check("t1_S2_filled", S2, 32'hDEADBEEF);
    wr = 1'b1; sel = 2'd2; E = 32'h12345678;
    async_reset("t1");
    check("t1_S2_zero", S2, 32'h0);

    // Basic routing on consecutive cycles
    step("t2_w0", 1'b1, 2'd0, 32'h11111111, 4'b0000);
    step("t2_w1", 1'b1, 2'd1, 32'h22222222, 4'b0000);
    step("t2_w2", 1'b1, 2'd2, 32'h33333333, 4'b0000);
    step("t2_w3", 1'b1, 2'd3, 32'h44444444, 4'b0000);
    check("t2_full", {28'd0, full}, 32'hF);
    check("t2_S0", S0, 32'h11111111);
    check("t2_S3", S3, 32'h44444444);
    step("t2_drain", 1'b0, 2'd0, 32'h0, 4'b1111);

    // Backpressure and sticky overflow
    step("t3_fill", 1'b1, 2'd1, 32'hA5A5A5A5, 4'b0000);
    step("t3_ovf", 1'b1, 2'd1, 32'h5A5A5A5A, 4'b0000);
    check("t3_S1_kept", S1, 32'hA5A5A5A5);
    check("t3_ovf_set", {31'd0, ovf}, 32'd1);
    step("t3_ack", 1'b0, 2'd1, 32'h0, 4'b0010);
    check("t3_ovf_sticky", {31'd0, ovf}, 32'd1);
    async_reset("t3");

    // Same-cycle drain and refill
    step("t4_fill", 1'b1, 2'd3, 32'h00000007, 4'b0000);
    step("t4_refill", 1'b1, 2'd3, 32'h00000008, 4'b1000);
    check("t4_S3", S3, 32'h00000008);
    check("t4_full3", {31'd0, full[3]}, 32'd1);
    check("t4_ovf", {31'd0, ovf}, 32'd0);
    step("t4_drain", 1'b0, 2'd0, 32'h0, 4'b1000);

    // Acks and a write on different slots in the same edge
    step("t5_f0", 1'b1, 2'd0, 32'h0000AAAA, 4'b0000);
    step("t5_f2", 1'b1, 2'd2, 32'h0000BBBB, 4'b0000);
    step("t5_mix", 1'b1, 2'd1, 32'hCAFEF00D, 4'b0101);
    check("t5_full", {28'd0, full}, 32'h2);
    check("t5_S0", S0, 32'h0000AAAA);
    check("t5_S1", S1, 32'hCAFEF00D);
    check("t5_S2", S2, 32'h0000BBBB);
    step("t5_drain", 1'b0, 2'd0, 32'h0, 4'b0010);

    // Spurious acks on empty slots, walking sel so ready is seen for every code
    for (int i = 0; i < 4; i++) begin
      step("t6_spur", 1'b0, 2'(i), $urandom, 4'b1111);
    end
    check("t6_full", {28'd0, full}, 32'h0);
    check("t6_ovf", {31'd0, ovf}, 32'd0);

    // Randomized traffic with periodic resets so ovf is exercised in both states
    for (int i = 0; i < 600; i++) begin
      if (i % 75 == 74) begin
        async_reset("rnd_rst");
      end else begin
        step("rnd", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
             4'($urandom_range(0, 15) & $urandom_range(0, 15)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
